// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants, FSM state type and scan divider helpers for the FND path
package fnd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int BCD_MAX    = 9999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    function automatic int calc_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

    function automatic int calc_cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - multi-cycle double-dabble converter with 9999 clamp and display register
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [BIN_W-1:0] i_value,
    input  logic             i_load,
    output logic             o_busy,
    output logic             o_ovf,
    output logic [BCD_W-1:0] o_bcd
);

    localparam int SR_W   = BCD_W + BIN_W;
    localparam int ITER_W = $clog2(BIN_W);

    conv_state_t       state, state_next;
    logic [SR_W-1:0]   shift_q;
    logic [SR_W-1:0]   adjusted;
    logic [ITER_W-1:0] iter_q;
    logic              over_max;

    assign over_max = (i_value > BIN_W'(BCD_MAX));
    assign o_busy   = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_load) state_next = SHIFT;
            SHIFT:   if (iter_q == ITER_W'(BIN_W - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Scratch BCD nibbles sit above the binary bits; adjust before each shift.
    always_comb begin
        adjusted = shift_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (shift_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                adjusted[BIN_W + 4*i +: 4] = shift_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift_q <= '0;
            iter_q  <= '0;
            o_ovf   <= 1'b0;
            o_bcd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_load) begin
                        shift_q <= {{BCD_W{1'b0}}, over_max ? BIN_W'(BCD_MAX) : i_value};
                        iter_q  <= '0;
                        o_ovf   <= over_max;
                    end
                end
                SHIFT: begin
                    shift_q <= {adjusted[SR_W-2:0], 1'b0};
                    iter_q  <= iter_q + 1'b1;
                end
                COMMIT: o_bcd <= shift_q[SR_W-1 -: BCD_W];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - 4-digit FND scan driver with prescaler, digit index and zero blanking
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [BIN_W-1:0] i_value,
    input  logic             i_load,
    output logic             o_busy,
    output logic             o_ovf,
    output logic [1:0]       o_digitSelect,
    output logic [3:0]       o_value,
    output logic             o_en
);

    localparam int DIV   = calc_div(CLK_HZ, SCAN_HZ);
    localparam int CNT_W = calc_cnt_w(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("fnd_scan_controller: CLK_HZ/SCAN_HZ must be at least 2");
    end

    logic [CNT_W-1:0] prescale_q;
    logic [1:0]       scan_idx_q;
    logic [BCD_W-1:0] bcd;
    logic             wrap;
    logic [3:0]       sel_nibble;
    logic             sel_en;

    bin2bcd_seq u_conv (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_value (i_value),
        .i_load  (i_load),
        .o_busy  (o_busy),
        .o_ovf   (o_ovf),
        .o_bcd   (bcd)
    );

    assign wrap = (prescale_q == CNT_W'(DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prescale_q <= '0;
            scan_idx_q <= '0;
        end else begin
            prescale_q <= wrap ? '0 : prescale_q + 1'b1;
            if (wrap) scan_idx_q <= scan_idx_q + 1'b1;
        end
    end

    // A digit stays lit if it or any more significant digit is non-zero.
    always_comb begin
        sel_nibble = bcd[{scan_idx_q, 2'b00} +: 4];
        sel_en     = 1'b1;
        if (LZ_BLANK) begin
            case (scan_idx_q)
                2'd1:    sel_en = |bcd[15:4];
                2'd2:    sel_en = |bcd[15:8];
                2'd3:    sel_en = |bcd[15:12];
                default: sel_en = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_digitSelect <= 2'd0;
            o_value       <= 4'd0;
            o_en          <= 1'b1;
        end else begin
            o_digitSelect <= scan_idx_q;
            o_value       <= sel_nibble;
            o_en          <= sel_en;
        end
    end

endmodule
